// File: rtl/ha_stim_checker.sv
// ha_stim_checker: sweeps the four half-adder input vectors and checks the returned sum/carry (option: HA_STIM_STOP_ON_ERR_EN ends a run at the first mismatch)
module ha_stim_checker #(
   parameter int NUM_PASSES = 1,
   parameter int ERR_W      = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             a_o,
   output logic             b_o,
   input  logic             s_i,
   input  logic             c_i,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic [1:0]       fail_vec
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_DRIVE = 2'd1;
   localparam logic [1:0] S_CHECK = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;
   logic [1:0]       state_q, state_d;
   logic [1:0]       idx_q, idx_d;
   logic [7:0]       pcnt_q, pcnt_d;
   logic             a_q, a_d, b_q, b_d;
   logic             pass_q, pass_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic [1:0]       fv_q, fv_d;
   logic             mism, last_pass, stop;
   // a_q/b_q are held from DRIVE through CHECK, so the registered s/c line up with them here
   assign mism      = (s_i != (a_q ^ b_q)) || (c_i != (a_q & b_q));
   assign last_pass = pcnt_q == 8'(NUM_PASSES - 1);
`ifdef HA_STIM_STOP_ON_ERR_EN
   assign stop = mism;
`else
   assign stop = 1'b0;
`endif
   assign a_o      = a_q;
   assign b_o      = b_q;
   assign busy     = (state_q == S_DRIVE) || (state_q == S_CHECK);
   assign done     = state_q == S_DONE;
   assign pass     = pass_q;
   assign err_cnt  = err_q;
   assign fail_vec = fv_q;
   // next-state: sequence vectors, count mismatches, decide when the run ends
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      pcnt_d  = pcnt_q;
      a_d     = a_q;
      b_d     = b_q;
      pass_d  = pass_q;
      err_d   = err_q;
      fv_d    = fv_q;
      case (state_q)
         S_IDLE: if (start) begin
            state_d = S_DRIVE;
            idx_d   = 2'd0;
            pcnt_d  = 8'd0;
            a_d     = 1'b0;
            b_d     = 1'b0;
            pass_d  = 1'b0;
            err_d   = '0;
            fv_d    = 2'd0;
         end
         S_DRIVE: state_d = S_CHECK;
         S_CHECK: begin
            if (mism) begin
               err_d = &err_q ? err_q : err_q + 1'b1;
               fv_d  = (err_q == '0) ? idx_q : fv_q;
            end
            if (stop || (idx_q == 2'd3 && last_pass)) begin
               state_d = S_DONE;
               a_d     = 1'b0;
               b_d     = 1'b0;
               pass_d  = !mism && (err_q == '0);
            end else begin
               state_d = S_DRIVE;
               idx_d   = idx_q + 2'd1;
               pcnt_d  = (idx_q == 2'd3) ? pcnt_q + 8'd1 : pcnt_q;
               a_d     = idx_d[1];
               b_d     = idx_d[0];
            end
         end
         default: state_d = S_IDLE;
      endcase
   end
   // state registers with synchronous reset to an idle, cleared checker
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= 2'd0;
         pcnt_q  <= 8'd0;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         fv_q    <= 2'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pcnt_q  <= pcnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         fv_q    <= fv_d;
      end
   end
endmodule

// File: doc/ha_stim_checker.md
HA_STIM_CHECKER -- requirements
Module: ha_stim_checker

Interface
REQ-001 Parameter NUM_PASSES, default 1, is the number of full sweeps over the 4 input vectors per run, legal range 1..255.
REQ-002 Parameter ERR_W, default 4, is the width of the mismatch counter.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 start  input  1  run request; sampled only in IDLE.
REQ-006 a_o  output  1  operand a driven to the half-adder interface (registered).
REQ-007 b_o  output  1  operand b driven to the half-adder interface (registered).
REQ-008 s_i  input  1  sum returned from the half-adder interface.
REQ-009 c_i  input  1  carry returned from the half-adder interface.
REQ-010 busy  output  1  high in DRIVE and CHECK.
REQ-011 done  output  1  one-cycle pulse in DONE.
REQ-012 pass  output  1  high when the last run completed with zero mismatches; held until the next accepted start.
REQ-013 err_cnt  output  ERR_W  mismatch count of the current or last run; saturates at all-ones.
REQ-014 fail_vec  output  2  index of the first failing vector {a,b}; valid when err_cnt is nonzero.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, DRIVE, CHECK and DONE.
REQ-016 IDLE with start=1 SHALL go to DRIVE, load vector index 0, clear err_cnt, pass and fail_vec, and clear the pass counter.
REQ-017 In DRIVE, a_o/b_o SHALL equal vector index bits [1]/[0] (order 00, 01, 10, 11); the next state SHALL be CHECK unconditionally.
REQ-018 a_o/b_o SHALL hold their value through CHECK, because the half adder registers s/c one cycle after sampling a/b.
REQ-019 In CHECK, a mismatch SHALL be s_i != (a_o XOR b_o) or c_i != (a_o AND b_o), and the comparison SHALL use s_i/c_i sampled at the end of the CHECK cycle.
REQ-020 On a mismatch, err_cnt SHALL increment, saturating at 2^ERR_W-1, and fail_vec SHALL latch the index only if err_cnt was 0.
REQ-021 From CHECK: if index<3, increment index and go to DRIVE; if index=3 and passes remain, wrap index to 0 and go to DRIVE; otherwise go to DONE.
REQ-022 In DONE, done=1 for exactly one cycle, pass SHALL be set to (err_cnt==0 including this run's final check), and the next state SHALL be IDLE.
REQ-023 Run latency with no early stop SHALL be 8*NUM_PASSES+1 cycles from the start-sampling edge to the DONE cycle.
REQ-024 start asserted outside IDLE SHALL be ignored, and start held high SHALL begin a new run on the first IDLE cycle after DONE.
REQ-025 In IDLE and DONE, a_o and b_o SHALL be 0.

Reset
REQ-026 rst=1 at any edge, including mid-run, SHALL force IDLE with a_o=b_o=busy=done=pass=0, err_cnt=0, fail_vec=0, and the index and pass counters at 0.
REQ-027 rst SHALL be shared with the half adder so that its s/c are 0 when the first run starts.

Configuration
REQ-028 With macro HA_STIM_STOP_ON_ERR_EN defined, the first mismatch in CHECK SHALL transition directly to DONE, with pass=0 and err_cnt=1.
REQ-029 Without HA_STIM_STOP_ON_ERR_EN, all 4*NUM_PASSES vectors SHALL always be checked, and fail_vec SHALL still record the first failure.

Verification
REQ-030 Correct half adder, NUM_PASSES=1, start pulse at cycle 0 -> DRIVE at cycle 1, done at cycle 9, pass=1, err_cnt=0.
REQ-031 Half adder with c stuck at 0, macro off -> vector 3 fails, done at cycle 9, err_cnt=1, fail_vec=3, pass=0.
REQ-032 s inverted, macro on -> failure at vector 0, done at cycle 3, err_cnt=1, fail_vec=0.
REQ-033 s inverted, NUM_PASSES=8, ERR_W=4, macro off -> 32 mismatches, err_cnt saturates at 15, done at cycle 65.
REQ-034 rst pulsed at cycle 5 of a run -> next cycle is IDLE with all outputs 0, and a new start completes normally with pass=1.
REQ-035 start re-pulsed while busy -> ignored, a single done pulse at cycle 9, and no restart.
